store_size_rmw: RTL and testbench
=================================

// Module: store_size_rmw
// PURPOSE
//  Store-side counterpart of the load-size path: performs sw/sh/sb to data memory on behalf of the
//  multicycle control unit. Word stores write directly; half/byte stores do a read-modify-write,
//  merging rs-data low bits into the low lanes of the addressed word and preserving the upper lanes.
//  Sits between the control unit (start/done handshake) and the data-memory port.
// PARAMETERS
//  MEM_LATENCY  1   cycles from mem_addr driven (mem_wr=0) to mem_rdata valid; legal range 1..7
// PORTS
//  clk                    in   1   system clock, rising edge
//  reset                  in   1   asynchronous, active-low reset
//  start                  in   1   request pulse; sampled only in IDLE
//  set_store_size_control in   2   00 byte, 01 half, 10 word, 11 reserved
//  address                in   32  target memory address (passed through unchanged)
//  b_reg_data             in   32  register value to store
//  mem_rdata              in   32  memory read data
//  mem_addr               out  32  memory address (registered)
//  mem_wr                 out  1   memory write strobe, one cycle per store
//  mem_wdata              out  32  memory write data (registered)
//  busy                   out  1   high from cycle after accepted start until DONE exits
//  done                   out  1   one-cycle completion pulse
//  size_error             out  1   one-cycle pulse with done when control was 11
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; mem_addr, mem_wdata = 0; mem_wr, busy, done, size_error = 0.
//    Reset mid-operation aborts immediately; no partial write is issued after reset asserts.
//  - States: IDLE, READ, WRITE, DONE.
//  - IDLE: on start=1 capture size, address, b_reg_data; mem_addr <= address.
//    size 10 -> WRITE with mem_wdata <= b_reg_data. size 00/01 -> READ, latency counter <= MEM_LATENCY.
//    size 11 -> DONE with size_error pulse, no memory access. start=0 -> stay IDLE.
//  - READ: mem_wr=0, mem_addr held; counter decrements each cycle; in the cycle counter==1, at the
//    clock edge sample mem_rdata and load mem_wdata <= merge(), go WRITE.
//    merge byte: {mem_rdata[31:8], b_reg_data[7:0]}; half: {mem_rdata[31:16], b_reg_data[15:0]}.
//  - WRITE: mem_wr=1 for exactly one cycle, mem_addr/mem_wdata stable; -> DONE.
//  - DONE: done=1 (size_error=1 if reserved) for one cycle; -> IDLE. Next start accepted in the
//    following IDLE cycle (start during DONE is ignored, not queued).
//  - start while busy is ignored; captured operands do not change during an operation.
//  - Latency (start accepted at edge 0): word: WRITE cycle 1, done cycle 2.
//    byte/half: READ cycles 1..MEM_LATENCY, WRITE cycle MEM_LATENCY+1, done MEM_LATENCY+2.
//    reserved: done+size_error cycle 1.
//  - Outputs mem_wr, done, size_error, busy decoded from registered state (glitch-free, no comb path
//    from start to any output).
// STRUCTURE
//  - Package store_size_pkg: size encodings (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10,
//    SIZE_RSVD=2'b11) and state enum (IDLE, READ, WRITE, DONE); shared with load-size and control.
//  - Sub-module store_merge: combinational lane merge (size, old word, new data -> merged word).
//  - Counter width $clog2(MEM_LATENCY+1).
// TESTING
//  1. sw: addr=0x40, b=0xDEADBEEF, size=10 -> mem_wr at cycle 1, mem_wdata=0xDEADBEEF, done cycle 2.
//  2. sb, L=1: mem[0x40]=0x11223344, b=0xAABBCCDD, size=00 -> one write 0x112233DD, done cycle 3.
//  3. sh, L=3: mem=0x11223344, b=0x0000CAFE, size=01 -> READ 3 cycles, write 0x1122CAFE, done cycle 5.
//  4. size=11 -> no mem_wr ever, done=1 and size_error=1 at cycle 1, back to IDLE.
//  5. start re-asserted every cycle during sb -> exactly one write, operands unchanged, done once.
//  6. reset low during READ of sb -> all outputs 0 at once, no mem_wr after release, IDLE accepts start.

Source files
------------

// File: rtl/store_size_pkg.sv
// Shared encodings for the load/store size paths and the store sequencer state.
package store_size_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/store_merge.sv
// Lane merge for partial stores: the low lanes come from the new data,
// and the remaining lanes keep the old memory word.
module store_merge
  import store_size_pkg::*;
(
  input  size_e       size,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged
);

  logic [3:0] lane_new;

  always_comb begin
    lane_new = 4'b0000;
    case (size)
      SIZE_BYTE: lane_new = 4'b0001;
      SIZE_HALF: lane_new = 4'b0011;
      SIZE_WORD: lane_new = 4'b1111;
      default:   lane_new = 4'b0000;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = lane_new[gi] ? new_data[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/store_size_rmw.sv
// Store sequencer: word stores write directly, byte/half stores read the
// target word, merge the low lanes and write it back.
module store_size_rmw
  import store_size_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  set_store_size_control,
  input  logic [31:0] address,
  input  logic [31:0] b_reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        size_error
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_e           state_reg;
  state_e           state_next;
  size_e            size_reg;
  size_e            size_in;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      data_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      merged;
  logic             last_read;

  assign size_in   = size_e'(set_store_size_control);
  assign last_read = (cnt_reg == CNT_W'(1));

  store_merge u_merge (
    .size     (size_reg),
    .old_word (mem_rdata),
    .new_data (data_reg),
    .merged   (merged)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (size_in)
            SIZE_WORD: state_next = WRITE;
            SIZE_RSVD: state_next = DONE;
            default:   state_next = READ;
          endcase
        end
      end
      READ:    if (last_read) state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      size_reg  <= SIZE_BYTE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            size_reg <= size_in;
            data_reg <= b_reg_data;
            addr_reg <= address;
            cnt_reg  <= CNT_W'(MEM_LATENCY);
            if (size_in == SIZE_WORD) wdata_reg <= b_reg_data;
          end
        end
        READ: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          // Read data is only guaranteed valid on the final latency cycle.
          if (last_read) wdata_reg <= merged;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_wr     = (state_reg == WRITE);
  assign done       = (state_reg == DONE);
  assign size_error = (state_reg == DONE) && (size_reg == SIZE_RSVD);
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_store_size_rmw.sv
// Bench for store_size_rmw: two instances (latency 1 and 3) share directed stimulus
// and are checked every cycle against a transaction-level model.
module tb_store_size_rmw;

  localparam int NDUT = 2;
  localparam int NOPS = 7;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] b;
    int          kind;      // 0 plain, 1 start held while busy, 2 reset during READ
    logic        exp_wr;
    logic [31:0] exp_wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  ctrl = 2'b00;
  logic [31:0] address = '0;
  logic [31:0] b_data = '0;

  logic [31:0] mem_rdata [NDUT];
  logic [31:0] mem_addr  [NDUT];
  logic [31:0] mem_wdata [NDUT];
  logic        mem_wr    [NDUT];
  logic        busy      [NDUT];
  logic        done      [NDUT];
  logic        size_error[NDUT];

  logic [31:0] mem  [NDUT][64];
  logic [31:0] a_d1 [NDUT];
  logic [31:0] a_d2 [NDUT];

  op_t ops [NOPS];
  int  op_idx = 0;
  bit  finish_req = 1'b0;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  // model state
  bit          txn_v     [NDUT];
  int          acc_edge  [NDUT];
  int          dur       [NDUT];
  int          free_edge [NDUT];
  int          m_op      [NDUT];
  logic [1:0]  m_size    [NDUT];
  logic [31:0] m_addr    [NDUT];
  logic [31:0] m_wdata   [NDUT];
  logic [31:0] last_addr [NDUT];
  logic [31:0] ref_mem   [NDUT][64];
  int          wr_in_op  [NDUT];
  logic [31:0] last_wr   [NDUT];

  always #5 clk = ~clk;

  store_size_rmw #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .start(start), .set_store_size_control(ctrl),
    .address(address), .b_reg_data(b_data), .mem_rdata(mem_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]),
    .busy(busy[0]), .done(done[0]), .size_error(size_error[0])
  );

  store_size_rmw #(.MEM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .start(start), .set_store_size_control(ctrl),
    .address(address), .b_reg_data(b_data), .mem_rdata(mem_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]),
    .busy(busy[1]), .done(done[1]), .size_error(size_error[1])
  );

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(int k);
    if (k == 16) return 32'h1122_3344;        // 0x40
    if (k == 32) return 32'h1122_3344;        // 0x80
    if (k == 48) return 32'h5566_7788;        // 0xC0
    return 32'h0F0F_0000 | k;
  endfunction

  function automatic logic [31:0] model_merge(logic [1:0] sz, logic [31:0] old, logic [31:0] nw);
    if (sz == 2'b00) return (old & 32'hFFFF_FF00) | (nw & 32'h0000_00FF);
    if (sz == 2'b01) return (old & 32'hFFFF_0000) | (nw & 32'h0000_FFFF);
    return nw;
  endfunction

  // Memory with MEM_LATENCY-cycle address-to-data delay per instance.
  assign mem_rdata[0] = mem[0][mem_addr[0][7:2]];
  assign mem_rdata[1] = mem[1][a_d2[1][7:2]];

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      a_d1[i] = '0;
      a_d2[i] = '0;
      for (int k = 0; k < 64; k++) mem[i][k] = init_word(k);
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NDUT; i++) begin
        a_d1[i] <= mem_addr[i];
        a_d2[i] <= a_d1[i];
        if (mem_wr[i]) mem[i][mem_addr[i][7:2]] <= mem_wdata[i];
      end
    end
  end

  // Model: accept a request when the instance is free, record what must follow.
  initial begin
    for (int i = 0; i < NDUT; i++) begin
      txn_v[i] = 1'b0; free_edge[i] = 0; last_addr[i] = '0;
      acc_edge[i] = 0; dur[i] = 0; m_op[i] = 0; m_size[i] = '0;
      m_addr[i] = '0; m_wdata[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (!reset) begin
          txn_v[i] = 1'b0;
          last_addr[i] = '0;
          free_edge[i] = 0;
        end else if (start && cyc >= free_edge[i]) begin
          txn_v[i]    = 1'b1;
          acc_edge[i] = cyc;
          m_size[i]   = ctrl;
          m_addr[i]   = address;
          m_op[i]     = op_idx;
          m_wdata[i]  = model_merge(ctrl, ref_mem[i][address[7:2]], b_data);
          dur[i]      = (ctrl == 2'b10) ? 2 : (ctrl == 2'b11) ? 1 : lat_of(i) + 2;
          free_edge[i] = cyc + dur[i] + 1;
          last_addr[i] = address;
        end
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut_l%0d cyc=%0d actual=%h required=%h", name, lat_of(i), cyc, act, exp);
    end
  endtask

  // Compare process: every cycle, every instance.
  initial begin
    for (int i = 0; i < NDUT; i++) begin
      wr_in_op[i] = 0;
      last_wr[i] = '0;
      for (int k = 0; k < 64; k++) ref_mem[i][k] = init_word(k);
    end
    forever begin
      @(negedge clk);
      if (finish_req) break;
      for (int i = 0; i < NDUT; i++) begin
        if (!reset) begin
          chk("rst_mem_wr", i, 32'(mem_wr[i]), 32'd0);
          chk("rst_busy", i, 32'(busy[i]), 32'd0);
          chk("rst_done", i, 32'(done[i]), 32'd0);
          chk("rst_size_error", i, 32'(size_error[i]), 32'd0);
          chk("rst_mem_addr", i, mem_addr[i], 32'd0);
          chk("rst_mem_wdata", i, mem_wdata[i], 32'd0);
        end else begin
          automatic int d = cyc - acc_edge[i];
          automatic bit act = txn_v[i] && d >= 1 && d <= dur[i];
          automatic int wr_at = (m_size[i] == 2'b10) ? 1 : lat_of(i) + 1;
          automatic bit e_wr = act && m_size[i] != 2'b11 && d == wr_at;
          automatic bit e_done = act && d == dur[i];
          automatic bit e_serr = e_done && m_size[i] == 2'b11;
          chk("busy", i, 32'(busy[i]), 32'(act));
          chk("mem_wr", i, 32'(mem_wr[i]), 32'(e_wr));
          chk("done", i, 32'(done[i]), 32'(e_done));
          chk("size_error", i, 32'(size_error[i]), 32'(e_serr));
          chk("mem_addr", i, mem_addr[i], last_addr[i]);
          if (act && d == 1) wr_in_op[i] = 0;
          if (mem_wr[i]) begin
            wr_in_op[i]++;
            last_wr[i] = mem_wdata[i];
          end
          if (e_wr) begin
            chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
            ref_mem[i][m_addr[i][7:2]] = m_wdata[i];
          end
          if (e_done) begin
            chk("op_write_count", i, wr_in_op[i], 32'(ops[m_op[i]].exp_wr));
            if (ops[m_op[i]].exp_wr) chk("op_literal_wdata", i, last_wr[i], ops[m_op[i]].exp_wdata);
            chk("op_size_error", i, 32'(size_error[i]), 32'(ops[m_op[i]].size == 2'b11));
            $display("txn dut_l%0d op=%0d size=%0d addr=%h wdata=%h writes=%0d size_error=%0b cyc=%0d",
                     lat_of(i), m_op[i], m_size[i], m_addr[i], last_wr[i], wr_in_op[i], size_error[i], cyc);
          end
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed stimulus with hand-computed expected write data.
  initial begin
    ops[0] = '{2'b00, 32'h40, 32'hAABB_CCDD, 0, 1'b1, 32'h1122_33DD};  // sb
    ops[1] = '{2'b10, 32'h40, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF};  // sw
    ops[2] = '{2'b01, 32'h80, 32'h0000_CAFE, 0, 1'b1, 32'h1122_CAFE};  // sh
    ops[3] = '{2'b11, 32'h44, 32'h1234_5678, 0, 1'b0, 32'h0};          // reserved
    ops[4] = '{2'b00, 32'hC0, 32'h1234_5678, 1, 1'b1, 32'h5566_7778};  // sb, start held
    ops[5] = '{2'b00, 32'h40, 32'h0000_0099, 2, 1'b0, 32'h0};          // sb aborted by reset
    ops[6] = '{2'b01, 32'h40, 32'h0000_1234, 0, 1'b1, 32'hDEAD_1234};  // sh after reset

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int j = 0; j < NOPS; j++) begin
      #1;
      op_idx  = j;
      start   = 1'b1;
      ctrl    = ops[j].size;
      address = ops[j].addr;
      b_data  = ops[j].b;
      @(posedge clk);
      #1;
      if (ops[j].kind == 1) begin
        repeat (3) begin
          b_data  = ~b_data;
          address = 32'h40;
          ctrl    = 2'b10;
          @(posedge clk);
          #1;
        end
        start = 1'b0;
      end else if (ops[j].kind == 2) begin
        start = 1'b0;
        reset = 1'b0;
        $display("txn op=%0d reset asserted during READ", j);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
      end else begin
        start   = 1'b0;
        ctrl    = 2'b11;
        address = 32'hFFFF_FFFC;
        b_data  = 32'h0BAD_0BAD;
      end
      repeat (8) @(posedge clk);
    end
    finish_req = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL compare process did not reach the summary");
    $fatal(1);
  end

endmodule
